// File: rtl/avg_pkg.sv
// Shared types and default widths for the AVG line-segment path.
package avg_pkg;

    localparam int unsigned COORD_W_DEF = 11;
    localparam int unsigned COLOR_W_DEF = 3;

    // One line segment as produced by the AVG core.
    typedef struct packed {
        logic [COORD_W_DEF-1:0] start_x;
        logic [COORD_W_DEF-1:0] start_y;
        logic [COORD_W_DEF-1:0] end_x;
        logic [COORD_W_DEF-1:0] end_y;
        logic [COLOR_W_DEF-1:0] color;
    } line_t;

    localparam int unsigned LINE_W_DEF = $bits(line_t);

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, status-flag and error-sticky control for a power-of-2 FIFO.
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_LEVEL = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       clr_err_i,
    input  logic                       wr_stb_i,
    input  logic                       rd_ack_i,
    output logic                       wr_do_o,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     hwm_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, hwm_q, hwm_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic          full, empty, rd_do, wr_do;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state for pointers, count, high-water mark and error stickies.
    always_comb begin
        rd_do       = rd_ack_i & ~empty;
        // A read in the same cycle frees a slot, so a full queue still accepts.
        wr_do       = wr_stb_i & (~full | rd_do);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        hwm_d       = hwm_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            hwm_d       = '0;
        end else begin
            if (rd_do) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_do) wr_ptr_d = wr_ptr_q + AW'(1);
            unique case ({wr_do, rd_do})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // Error event in the same cycle as clr_err keeps the flag set.
            if (wr_stb_i & full & ~rd_do) overflow_d = 1'b1;
            else if (clr_err_i)           overflow_d = 1'b0;
            if (rd_ack_i & empty)         underflow_d = 1'b1;
            else if (clr_err_i)           underflow_d = 1'b0;
            if (clr_err_i || (count_d > hwm_q)) hwm_d = count_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hwm_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hwm_q       <= hwm_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_do_o       = wr_do & ~flush_i;
    assign wr_ptr_o      = wr_ptr_q;
    assign rd_ptr_o      = rd_ptr_q;
    assign count_o       = count_q;
    assign hwm_o         = hwm_q;
    assign full_o        = full;
    assign empty_o       = empty;
    assign almost_full_o = (count_q >= CW'(AFULL_LEVEL));
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

endmodule

// File: rtl/line_seg_fifo.sv
// Line-segment queue between the AVG core and the vector rasteriser.
// Holds the storage array, write-strobe generation and the show-ahead output mask.
module line_seg_fifo
    import avg_pkg::*;
#(
    parameter int unsigned COORD_W     = COORD_W_DEF,
    parameter int unsigned COLOR_W     = COLOR_W_DEF,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_LEVEL = 6,
    parameter bit          EDGE_WRITE  = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          clr_err_i,
    input  logic                          wr_req_i,
    input  logic [4*COORD_W+COLOR_W-1:0]  wr_line_i,
    input  logic                          rd_ack_i,
    output logic [4*COORD_W+COLOR_W-1:0]  rd_line_o,
    output logic                          rd_valid_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [$clog2(DEPTH):0]        hwm_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int unsigned LINE_W = 4 * COORD_W + COLOR_W;
    localparam int unsigned AW     = $clog2(DEPTH);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic              wr_req_q;
    logic              wr_stb, wr_do, empty;
    logic [AW-1:0]     wr_ptr, rd_ptr;

    assign wr_stb = EDGE_WRITE ? (wr_req_i & ~wr_req_q) : wr_req_i;

    // Write-request history for edge detection; tracks through flush too.
    always_ff @(posedge clk_i) begin
        if (rst_i) wr_req_q <= 1'b0;
        else       wr_req_q <= wr_req_i;
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_do) mem_q[wr_ptr] <= wr_line_i;
    end

    fifo_ptr_ctrl #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) u_ctrl (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .clr_err_i     (clr_err_i),
        .wr_stb_i      (wr_stb),
        .rd_ack_i      (rd_ack_i),
        .wr_do_o       (wr_do),
        .wr_ptr_o      (wr_ptr),
        .rd_ptr_o      (rd_ptr),
        .count_o       (count_o),
        .hwm_o         (hwm_o),
        .full_o        (full_o),
        .empty_o       (empty),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    // Show-ahead head entry, forced to zero when nothing is queued.
    always_comb begin
        rd_line_o = '0;
        if (!empty) rd_line_o = mem_q[rd_ptr];
    end

    assign empty_o    = empty;
    assign rd_valid_o = ~empty;

endmodule
